// File: rtl/mul_div_unit.sv
// Multi-cycle MIPS-style multiply/divide unit owning the architectural HI/LO
// registers. Results are computed at acceptance and committed after N busy cycles.
module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [3:0]  MDUOp,
    input  logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    logic        res_wr_q, res_wr_d;

    logic [63:0] prod_s_s;
    logic [63:0] prod_u_s;
    logic [31:0] divu_b_s;
    logic [31:0] a_abs_s;
    logic [31:0] b_abs_s;
    logic [31:0] q_abs_s;
    logic [31:0] r_abs_s;
    logic [31:0] q_u_s;
    logic [31:0] r_u_s;
    logic [31:0] q_s_s;
    logic [31:0] r_s_s;

    // Two's-complement magnitude; 0x80000000 maps to itself, which is correct unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    // Datapath: every candidate result, with divisor forced nonzero to keep it defined.
    always_comb begin
        prod_s_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
        prod_u_s = {32'd0, A} * {32'd0, B};
        divu_b_s = (B == 32'd0) ? 32'd1 : B;
        q_u_s    = A / divu_b_s;
        r_u_s    = A % divu_b_s;
        a_abs_s  = abs32(A);
        b_abs_s  = (B == 32'd0) ? 32'd1 : abs32(B);
        q_abs_s  = a_abs_s / b_abs_s;
        r_abs_s  = a_abs_s % b_abs_s;
        q_s_s    = (A[31] ^ B[31]) ? (32'd0 - q_abs_s) : q_abs_s;
        r_s_s    = A[31] ? (32'd0 - r_abs_s) : r_abs_s;
    end

    // Next-state logic: acceptance in IDLE, countdown and commit in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (MDUOp)
                        OP_MULT: begin
                            state_d  = S_RUN;
                            cnt_d    = 5'(MULT_CYCLES);
                            res_hi_d = prod_s_s[63:32];
                            res_lo_d = prod_s_s[31:0];
                            res_wr_d = 1'b1;
                        end
                        OP_MULTU: begin
                            state_d  = S_RUN;
                            cnt_d    = 5'(MULT_CYCLES);
                            res_hi_d = prod_u_s[63:32];
                            res_lo_d = prod_u_s[31:0];
                            res_wr_d = 1'b1;
                        end
                        OP_DIV: begin
                            state_d  = S_RUN;
                            cnt_d    = 5'(DIV_CYCLES);
                            res_hi_d = r_s_s;
                            res_lo_d = q_s_s;
                            res_wr_d = (B != 32'd0);
                        end
                        OP_DIVU: begin
                            state_d  = S_RUN;
                            cnt_d    = 5'(DIV_CYCLES);
                            res_hi_d = r_u_s;
                            res_lo_d = q_u_s;
                            res_wr_d = (B != 32'd0);
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt_q == 5'd1) begin
                    state_d = S_IDLE;
                    cnt_d   = 5'd0;
                    if (res_wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and architectural registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected HI/LO and busy
// length; a negedge monitor checks them whenever busy falls.
module tb_mul_div_unit;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  MDUOp;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDUOp (MDUOp),
        .start (start),
        .busy  (busy),
        .HI    (HI),
        .LO    (LO)
    );

    typedef struct {
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic [31:0] new_hi;
        logic [31:0] new_lo;
        int          ncyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] m_hi   = 32'd0;
    logic [31:0] m_lo   = 32'd0;
    logic        prev_busy = 1'b0;
    int          busy_cnt  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%08h required=%08h", name, act, req);
        end
    endtask

    // Start a request at the current negedge; returns at the next negedge with start low.
    task automatic pulse(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        A = a; B = b; MDUOp = op; start = 1'b1;
        @(negedge clk);
        start = 1'b0; MDUOp = 4'd0;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] nh, input logic [31:0] nl, input int n);
        exp_t e;
        e.old_hi = m_hi; e.old_lo = m_lo;
        e.new_hi = nh;   e.new_lo = nl;
        e.ncyc   = n;
        sb.push_back(e);
        m_hi = nh; m_lo = nl;
        pulse(op, a, b);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy === 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (busy !== 1'b0) begin
            n_vec++; n_fail++;
            $display("FAIL wait_idle timeout busy=%b required=0", busy);
        end
    endtask

    // Monitor: hold check while busy, result and busy length check on busy fall.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            busy_cnt = prev_busy ? busy_cnt + 1 : 1;
            if (sb.size() == 0) begin
                chk("unexpected_busy", 32'(busy), 32'd0);
            end else begin
                chk("hold_hi", HI, sb[0].old_hi);
                chk("hold_lo", LO, sb[0].old_lo);
            end
        end else if (prev_busy && sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("result_hi", HI, e.new_hi);
            chk("result_lo", LO, e.new_lo);
            chk("busy_cycles", 32'(busy_cnt), 32'(e.ncyc));
        end
        prev_busy = busy;
    end

    initial begin
        reset = 1'b1; A = 32'd0; B = 32'd0; MDUOp = 4'd0; start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);

        issue(4'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5); wait_idle();
        issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5); wait_idle();
        issue(4'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10); wait_idle();
        issue(4'd4, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 10); wait_idle();
        issue(4'd3, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10); wait_idle();
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10); wait_idle();

        pulse(4'd5, 32'h1234_5678, 32'd0);
        m_hi = 32'h1234_5678;
        chk("mthi_hi", HI, m_hi);
        chk("mthi_lo", LO, m_lo);
        chk("mthi_busy", 32'(busy), 32'd0);

        pulse(4'd6, 32'hA5A5_A5A5, 32'd0);
        m_lo = 32'hA5A5_A5A5;
        chk("mtlo_lo", LO, m_lo);
        chk("mtlo_hi", HI, m_hi);
        issue(4'd4, 32'h0000_0064, 32'h0000_0000, m_hi, m_lo, 10); wait_idle();

        // Starts during busy, with operand churn, must not disturb the DIV.
        issue(4'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10);
        @(negedge clk);
        pulse(4'd5, 32'hDEAD_BEEF, 32'h0000_0001);
        pulse(4'd1, 32'h0000_0003, 32'h0000_0003);
        A = 32'h1111_1111; B = 32'h0; MDUOp = 4'd4;
        wait_idle();
        MDUOp = 4'd0;
        chk("div_hi_not_deadbeef", 32'(HI == 32'hDEAD_BEEF), 32'd0);

        // Start sampled at the commit edge is ignored; the next cycle's start is taken.
        issue(4'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5);
        repeat (4) @(negedge clk);
        pulse(4'd5, 32'h5555_5555, 32'd0);
        chk("edge_start_busy_low", 32'(busy), 32'd0);
        issue(4'd2, 32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A, 5);
        chk("b2b_busy", 32'(busy), 32'd1);
        wait_idle();

        // Reset during the third busy cycle of a DIV.
        issue(4'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0000, 32'h0000_0000, 3);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            chk("post_reset_busy", 32'(busy), 32'd0);
            chk("post_reset_hi", HI, 32'd0);
            chk("post_reset_lo", LO, 32'd0);
        end

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
